// File: rtl/processor_pkg.sv
// Shared definitions for the parameterised multi-cycle processor:
// opcode encodings and the control state enum.
package processor_pkg;

   localparam logic [2:0] OP_MV   = 3'd0;
   localparam logic [2:0] OP_MVI  = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_OR   = 3'd5;
   localparam logic [2:0] OP_XOR  = 3'd6;
   localparam logic [2:0] OP_MVNZ = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2,
      T3   = 2'd3
   } state_t;

endpackage

// File: rtl/processor_param_alu.sv
// Combinational ALU: add/sub with carry-out (borrow on sub) and bitwise
// logic ops, all modulo 2^DW.
module alu_n
   import processor_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [2:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result,
   output logic          carry
);

   logic [DW:0] sum;
   logic [DW:0] diff;

   // Zero-extended subtraction leaves the borrow in the top bit.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: {carry, result} = sum;
         OP_SUB: {carry, result} = diff;
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/processor_param.sv
// Multi-cycle bus-based processor: NREG general registers, A/G ALU staging
// registers, one-hot driven internal bus and a four-state control FSM.
module processor_param
   import processor_pkg::*;
#(
   parameter int DW   = 16,
   parameter int NREG = 8
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic [DW-1:0] DIN,
   input  logic          Run,
   output logic          Done,
   output logic [DW-1:0] BUS,
   output logic          Z,
   output logic          C,
   output logic [1:0]    state
);

   localparam int RW = $clog2(NREG);
   localparam int IW = 3 + 2*RW;

   // Run/Done handshake: Run is sampled only while IDLE, and the rising edge
   // that sees it loads IR from DIN; Done is high for exactly the last cycle
   // of each instruction, the cycle whose closing edge performs the write.
   state_t          cur_state, nxt_state;
   logic [IW-1:0]   ir;
   logic [2:0]      opcode;
   logic [RW-1:0]   rx, ry;
   logic [DW-1:0]   regs [NREG];
   logic [DW-1:0]   a_reg, g_reg;
   logic [DW-1:0]   alu_result;
   logic            alu_carry;
   logic            sel_din, sel_g, a_in, g_in;
   logic [NREG-1:0] sel_r, wr_r;

   assign opcode = ir[IW-1:2*RW];
   assign rx     = ir[2*RW-1:RW];
   assign ry     = ir[RW-1:0];
   assign state  = cur_state;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) cur_state <= IDLE;
      else       cur_state <= nxt_state;
   end

   always_comb begin
      nxt_state = cur_state;
      sel_din   = 1'b0;
      sel_g     = 1'b0;
      sel_r     = '0;
      wr_r      = '0;
      a_in      = 1'b0;
      g_in      = 1'b0;
      Done      = 1'b0;
      case (cur_state)
         IDLE: if (Run) nxt_state = T1;
         T1: begin
            case (opcode)
               OP_MV: begin
                  sel_r[ry] = 1'b1;
                  wr_r[rx]  = 1'b1;
                  Done      = 1'b1;
                  nxt_state = IDLE;
               end
               OP_MVI: begin
                  sel_din   = 1'b1;
                  wr_r[rx]  = 1'b1;
                  Done      = 1'b1;
                  nxt_state = IDLE;
               end
               // Done does not depend on Z; only the write is conditional.
               OP_MVNZ: begin
                  sel_r[ry] = 1'b1;
                  wr_r[rx]  = ~Z;
                  Done      = 1'b1;
                  nxt_state = IDLE;
               end
               default: begin
                  sel_r[rx] = 1'b1;
                  a_in      = 1'b1;
                  nxt_state = T2;
               end
            endcase
         end
         T2: begin
            sel_r[ry] = 1'b1;
            g_in      = 1'b1;
            nxt_state = T3;
         end
         T3: begin
            sel_g     = 1'b1;
            wr_r[rx]  = 1'b1;
            Done      = 1'b1;
            nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Sources are one-hot, so OR-ing the selected ones is the mux; none -> 0.
   always_comb begin
      BUS = '0;
      if (sel_din) BUS = BUS | DIN;
      if (sel_g)   BUS = BUS | g_reg;
      for (int i = 0; i < NREG; i++) begin
         if (sel_r[i]) BUS = BUS | regs[i];
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)                        ir <= '0;
      else if (cur_state == IDLE && Run) ir <= DIN[IW-1:0];
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (wr_r[i]) regs[i] <= BUS;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         a_reg <= '0;
         g_reg <= '0;
         Z     <= 1'b0;
         C     <= 1'b0;
      end else begin
         if (a_in) a_reg <= BUS;
         if (g_in) begin
            g_reg <= alu_result;
            Z     <= (alu_result == '0);
            C     <= alu_carry;
         end
      end
   end

   alu_n #(.DW(DW)) u_alu (
      .op     (opcode),
      .a      (a_reg),
      .b      (BUS),
      .result (alu_result),
      .carry  (alu_carry)
   );

endmodule

// File: tb/tb_processor_param.sv
// Directed bench for processor_param: a 16-bit/8-register and a
// 32-bit/16-register instance, checked by Done-cycle scoreboards.
module tb_processor_param;
   import processor_pkg::*;

   localparam int DW   = 16;
   localparam int NREG = 8;
   localparam int BDW  = 32;
   localparam int BNREG = 16;

   logic            clk, rst;
   logic [DW-1:0]   din, bus;
   logic            run, done, z, c;
   logic [1:0]      state;
   logic [BDW-1:0]  b_din, b_bus;
   logic            b_run, b_done, b_z, b_c;
   logic [1:0]      b_state;

   int checks = 0;
   int errors = 0;
   logic [DW+1:0]  exp_q[$];
   logic [BDW+1:0] b_exp_q[$];
   logic [DW+1:0]  e16;
   logic [BDW+1:0] e32;
   int idle_bad;

   processor_param #(.DW(DW), .NREG(NREG)) dut (
      .Clock(clk), .Reset(rst), .DIN(din), .Run(run), .Done(done),
      .BUS(bus), .Z(z), .C(c), .state(state)
   );

   processor_param #(.DW(BDW), .NREG(BNREG)) dut_big (
      .Clock(clk), .Reset(rst), .DIN(b_din), .Run(b_run), .Done(b_done),
      .BUS(b_bus), .Z(b_z), .C(b_c), .state(b_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Done-cycle monitors: BUS carries the value being written, flags as seen.
   always @(negedge clk) begin
      if (!rst && done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done16_unexpected got z=%0b c=%0b bus=%h", z, c, bus);
         end else begin
            e16 = exp_q.pop_front();
            if ({z, c, bus} !== e16) begin
               errors++;
               $display("FAIL done16 got z=%0b c=%0b bus=%h exp z=%0b c=%0b bus=%h",
                        z, c, bus, e16[DW+1], e16[DW], e16[DW-1:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b_done) begin
         checks++;
         if (b_exp_q.size() == 0) begin
            errors++;
            $display("FAIL done32_unexpected got z=%0b c=%0b bus=%h", b_z, b_c, b_bus);
         end else begin
            e32 = b_exp_q.pop_front();
            if ({b_z, b_c, b_bus} !== e32) begin
               errors++;
               $display("FAIL done32 got z=%0b c=%0b bus=%h exp z=%0b c=%0b bus=%h",
                        b_z, b_c, b_bus, e32[BDW+1], e32[BDW], e32[BDW-1:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ins(input int rw, input logic [2:0] op, input int x, input int y);
      return (32'(op) << (2*rw)) | (32'(x) << rw) | 32'(y);
   endfunction

   // Issue one instruction and wait for its Done, checking the latency.
   task automatic exec(input bit big, input logic [2:0] op, input int x, input int y,
                       input logic [31:0] imm, input bit pulse_t2);
      int lat;
      int exp_lat;
      bit seen;
      logic [31:0] w;
      exp_lat = (op == OP_MV || op == OP_MVI || op == OP_MVNZ) ? 2 : 4;
      @(posedge clk); #1;
      if (big) begin
         b_din = ins(4, op, x, y);
         b_run = 1'b1;
      end else begin
         w   = ins(3, op, x, y);
         din = w[DW-1:0];
         run = 1'b1;
      end
      @(posedge clk); #1;
      run   = 1'b0;
      b_run = 1'b0;
      if (op == OP_MVI) begin
         if (big) b_din = imm;
         else     din   = imm[DW-1:0];
      end
      lat  = 1;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clk);
         lat++;
         if (pulse_t2 && lat == 3) begin
            w   = ins(3, OP_MVI, 0, 0);
            din = w[DW-1:0];
            run = 1'b1;
         end
         if (pulse_t2 && lat == 4) run = 1'b0;
         if (big ? b_done : done) seen = 1'b1;
      end
      check($sformatf("latency_op%0d_big%0d", op, big), seen ? lat : 99, exp_lat);
   endtask

   task automatic do16(input logic [2:0] op, input int x, input int y, input logic [15:0] imm,
                       input logic ez, input logic ec, input logic [15:0] ev);
      exp_q.push_back({ez, ec, ev});
      exec(1'b0, op, x, y, {16'h0, imm}, 1'b0);
   endtask

   task automatic do32(input logic [2:0] op, input int x, input int y, input logic [31:0] imm,
                       input logic ez, input logic ec, input logic [31:0] ev);
      b_exp_q.push_back({ez, ec, ev});
      exec(1'b1, op, x, y, imm, 1'b0);
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; din = '0; b_run = 1'b0; b_din = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_state", state, 2'd0);
      check("rst_done", done, 1'b0);
      check("rst_bus", bus, 16'h0);
      check("rst_zc", {z, c}, 2'b00);
      check("rst_big_state", b_state, 2'd0);
      @(posedge clk); #1 rst = 1'b0;

      idle_bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (state != 2'd0 || done != 1'b0 || bus != 16'h0) idle_bad++;
      end
      check("idle_hold", idle_bad, 0);

      do16(OP_MV,   3, 3, 16'h0,    0, 0, 16'h0000);
      do16(OP_MVI,  0, 0, 16'h0005, 0, 0, 16'h0005);
      do16(OP_MVI,  1, 0, 16'h0003, 0, 0, 16'h0003);
      do16(OP_ADD,  0, 1, 16'h0,    0, 0, 16'h0008);
      do16(OP_MV,   0, 0, 16'h0,    0, 0, 16'h0008);

      do16(OP_MVI,  4, 0, 16'h1234, 0, 0, 16'h1234);
      do16(OP_MVI,  5, 0, 16'h5678, 0, 0, 16'h5678);
      do16(OP_MVI,  2, 0, 16'h0003, 0, 0, 16'h0003);
      do16(OP_MVI,  3, 0, 16'h0003, 0, 0, 16'h0003);
      do16(OP_SUB,  2, 3, 16'h0,    1, 0, 16'h0000);
      do16(OP_MVNZ, 4, 5, 16'h0,    1, 0, 16'h5678);
      do16(OP_MV,   4, 4, 16'h0,    1, 0, 16'h1234);
      do16(OP_MV,   2, 2, 16'h0,    1, 0, 16'h0000);

      do16(OP_MVI,  0, 0, 16'hFFFF, 1, 0, 16'hFFFF);
      do16(OP_MVI,  1, 0, 16'h0001, 1, 0, 16'h0001);
      do16(OP_ADD,  0, 1, 16'h0,    1, 1, 16'h0000);
      do16(OP_MV,   0, 0, 16'h0,    1, 1, 16'h0000);
      do16(OP_MVI,  6, 0, 16'h0001, 1, 1, 16'h0001);
      do16(OP_MVI,  7, 0, 16'h0002, 1, 1, 16'h0002);
      do16(OP_SUB,  6, 7, 16'h0,    0, 1, 16'hFFFF);
      do16(OP_MVNZ, 4, 5, 16'h0,    0, 1, 16'h5678);
      do16(OP_MV,   4, 4, 16'h0,    0, 1, 16'h5678);
      do16(OP_ADD,  7, 7, 16'h0,    0, 0, 16'h0004);

      do16(OP_MVI,  1, 0, 16'h0F0F, 0, 0, 16'h0F0F);
      do16(OP_MVI,  2, 0, 16'h00FF, 0, 0, 16'h00FF);
      do16(OP_AND,  1, 2, 16'h0,    0, 0, 16'h000F);
      do16(OP_OR,   1, 2, 16'h0,    0, 0, 16'h00FF);
      do16(OP_XOR,  1, 6, 16'h0,    0, 0, 16'hFF00);

      // Run pulse while in T2 must not disturb the add in flight.
      exp_q.push_back({1'b0, 1'b0, 16'h0008});
      exec(1'b0, OP_ADD, 7, 7, 32'h0, 1'b1);
      do16(OP_MV,   7, 7, 16'h0,    0, 0, 16'h0008);
      do16(OP_XOR,  2, 2, 16'h0,    1, 0, 16'h0000);

      // Reset in T2 of add R0,R1.
      @(posedge clk); #1;
      din = 16'(ins(3, OP_ADD, 0, 1));
      run = 1'b1;
      @(posedge clk); #1 run = 1'b0;
      @(posedge clk); #1;
      check("abort_in_t2", state, 2'd2);
      rst = 1'b1;
      #1;
      check("abort_state", state, 2'd0);
      check("abort_bus", bus, 16'h0);
      check("abort_done", done, 1'b0);
      check("abort_zc", {z, c}, 2'b00);
      @(posedge clk); #1 rst = 1'b0;
      do16(OP_MV,   1, 1, 16'h0,    0, 0, 16'h0000);
      do16(OP_MV,   7, 7, 16'h0,    0, 0, 16'h0000);
      do16(OP_MVI,  3, 0, 16'hABCD, 0, 0, 16'hABCD);
      do16(OP_MV,   0, 3, 16'h0,    0, 0, 16'hABCD);

      do32(OP_MVI, 15,  0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
      do32(OP_XOR, 15, 15, 32'h0,        1, 0, 32'h00000000);
      do32(OP_MV,  15, 15, 32'h0,        1, 0, 32'h00000000);
      do32(OP_MVI,  9,  0, 32'h80000000, 1, 0, 32'h80000000);
      do32(OP_MV,   9,  9, 32'h0,        1, 0, 32'h80000000);

      repeat (3) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      check("b_exp_q_drained", b_exp_q.size(), 0);
      check("final_idle", state, 2'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
